// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StStop  = 2'd2
  } fetch_state_t;

  localparam int unsigned FBUF_DEPTH   = 2;
  localparam int unsigned FETCH_BITS   = 64;
  localparam int unsigned FETCH_DEPTH  = 32;
  localparam int unsigned FETCH_ADDR_W = $clog2(FETCH_DEPTH);

  // One buffered instruction and the word index it was fetched from.
  typedef struct packed {
    logic [FETCH_BITS-1:0]   data;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory, redirect and decode-handshake signals of the fetch sequencer.
interface fetch_sequencer_if #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned BITS  = 64
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              run;
  logic [ADDR_W-1:0] mem_addr;
  logic [BITS-1:0]   mem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [BITS-1:0]   instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              busy;

  // Sequencer side.
  modport master (
    input  run, mem_rdata, redirect_valid, redirect_pc, instr_ready,
    output mem_addr, instr_valid, instr_data, instr_pc, busy
  );

  // Memory / decode / control side.
  modport slave (
    output run, mem_rdata, redirect_valid, redirect_pc, instr_ready,
    input  mem_addr, instr_valid, instr_data, instr_pc, busy
  );
endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO holding returned instructions until decode accepts them.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);
  localparam int unsigned PtrW = $clog2(FBUF_DEPTH);

  fetch_entry_t    entries_q [FBUF_DEPTH];
  fetch_entry_t    entries_d [FBUF_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            do_push, do_pop;

  // Next-state: flush wins over any push/pop in the same cycle.
  always_comb begin
    entries_d = entries_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    do_push   = push_i && (count_q != 2'(FBUF_DEPTH));
    do_pop    = pop_i && (count_q != 2'd0);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        entries_d[wr_ptr_q] = entry_i;
        wr_ptr_d            = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FBUF_DEPTH; i++) entries_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // Head and occupancy outputs.
  always_comb begin
    head_o  = entries_q[rd_ptr_q];
    count_o = count_q;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC, issue credit, redirect kill and run/stop control for instruction memory.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = FETCH_DEPTH,
  parameter int unsigned BITS     = FETCH_BITS,
  parameter int unsigned RESET_PC = 0
) (
  input logic              clk,
  input logic              rst_n,
  fetch_sequencer_if.master bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  // The buffer entry type is sized from the package; reject mismatched builds.
  if (BITS != FETCH_BITS || ADDR_W != FETCH_ADDR_W) begin : g_cfg_check
    $error("fetch_sequencer: DEPTH/BITS must match fetch_pkg entry widths");
  end

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              issue, pop, push, instr_valid;
  logic [2:0]        credit_used;
  logic [1:0]        count;
  fetch_entry_t      push_entry, head;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.run) state_d = StFetch;
      StFetch: if (!bus.run) state_d = StStop;
      StStop: begin
        if (bus.run)          state_d = StFetch;
        else if (!inflight_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Issue only if the returning word is guaranteed a buffer slot; a redirect
  // suppresses the issue and kills any response arriving this cycle.
  always_comb begin
    instr_valid = (count != 2'd0);
    pop         = instr_valid && bus.instr_ready;
    credit_used = 3'(count) + 3'(inflight_q);
    issue       = (state_q == StFetch) && !bus.redirect_valid &&
                  (credit_used < 3'(FBUF_DEPTH) + 3'(pop));
    push        = inflight_q && !bus.redirect_valid;
    push_entry.data = bus.mem_rdata;
    push_entry.pc   = req_pc_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    inflight_d  = issue;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end else if (issue) begin
      pc_d     = pc_q + ADDR_W'(1);
      req_pc_d = pc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= ADDR_W'(RESET_PC);
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .entry_i (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  // Outputs.
  always_comb begin
    bus.mem_addr    = pc_q;
    bus.instr_valid = instr_valid;
    bus.instr_data  = head.data;
    bus.instr_pc    = head.pc;
    bus.busy        = (state_q != StIdle) || inflight_q;
  end
endmodule
